// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the pipeline hazard controller
//
// Contents:
//   SB_DEST_W  : width of the stored destination index (register widths up to 8 bits)
//   REG_ZERO   : register 0, hard-wired to zero and never a dependence
//   sb_slot_t  : one scoreboard slot {valid, dest, is_load}
//   fwd_sel_t  : operand source select (regfile, EXE, MEM, WB)
//   slot_match : true when a slot holds a live non-zero writer of the given register
package hazard_pkg;

  localparam int SB_DEST_W = 8;
  localparam logic [SB_DEST_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                 valid;
    logic [SB_DEST_W-1:0] dest;
    logic                 is_load;
  } sb_slot_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EXE = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  function automatic logic slot_match(input sb_slot_t s, input logic [SB_DEST_W-1:0] src);
    return s.valid && (s.dest != REG_ZERO) && (s.dest == src);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - three-slot shadow scoreboard of in-flight register writers
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (clears every slot)
//   in_valid        : writer entering EXE this edge (already gated by bubble)
//   in_dest         : destination register of that writer
//   in_is_load      : writer is a load
//   src1, src2      : source registers of the decoding instruction
//   match1, match2  : per-slot matches, bit 0 = EXE, bit 1 = MEM, bit 2 = WB
//   exe_is_load     : the EXE slot holds a load
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [REG_W-1:0] in_dest,
  input  logic             in_is_load,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  output logic [2:0]       match1,
  output logic [2:0]       match2,
  output logic             exe_is_load
);

  sb_slot_t exe_q, mem_q, wb_q;
  sb_slot_t exe_d, mem_d, wb_d;
  logic [SB_DEST_W-1:0] src1_w, src2_w;

  always_comb begin
    exe_d         = '0;
    exe_d.valid   = in_valid;
    exe_d.dest    = SB_DEST_W'(in_dest);
    exe_d.is_load = in_is_load;
    // The shift never stalls: downstream stages always advance.
    mem_d         = exe_q;
    wb_d          = mem_q;

    src1_w = SB_DEST_W'(src1);
    src2_w = SB_DEST_W'(src2);
    match1 = {slot_match(wb_q, src1_w), slot_match(mem_q, src1_w), slot_match(exe_q, src1_w)};
    match2 = {slot_match(wb_q, src2_w), slot_match(mem_q, src2_w), slot_match(exe_q, src2_w)};
  end

  assign exe_is_load = exe_q.is_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - decode-stage hazard controller: stall, bubble, flush, forwarding
//
// Build option: define HAZARD_FORWARDING_EN to include operand forwarding
// (only load-use stalls); otherwise any EXE/MEM/WB match stalls and the
// forwarding selects are tied to the register file.
//
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   id_valid                : ID holds a real instruction
//   id_src1, id_src2        : source registers; id_src2_used qualifies src2
//   id_dest, id_wb_en       : destination and write enable of the ID instruction
//   id_mem_r_en             : ID instruction is a load
//   exe_br_taken            : branch resolved taken in EXE this cycle
//   freeze                  : hold PC and IF/ID
//   bubble                  : load NOP controls into ID/EXE
//   flush_if                : invalidate IF/ID on the next edge
//   fwd_sel_a, fwd_sel_b    : 0 regfile, 1 EXE, 2 MEM, 3 WB
//   stall_cnt               : saturating count of freeze cycles
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src2_used,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             exe_br_taken,
  output logic             freeze,
  output logic             bubble,
  output logic             flush_if,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [2:0]       match1, match2;
  logic             exe_is_load;
  logic             hazard;
  logic             sb_in_valid;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  hazard_scoreboard #(.REG_W(REG_W)) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (sb_in_valid),
    .in_dest     (id_dest),
    .in_is_load  (id_mem_r_en),
    .src1        (id_src1),
    .src2        (id_src2),
    .match1      (match1),
    .match2      (match2),
    .exe_is_load (exe_is_load)
  );

`ifdef HAZARD_FORWARDING_EN
  // Youngest producer wins. A load in EXE has no result yet, so it is
  // skipped here; the stall logic holds the consumer until it reaches MEM.
  function automatic fwd_sel_t pick_fwd(input logic [2:0] m, input logic exe_ld);
    if (m[0] && !exe_ld) return FWD_EXE;
    if (m[1])            return FWD_MEM;
    if (m[2])            return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    hazard    = exe_is_load & (match1[0] | (id_src2_used & match2[0]));
    fwd_sel_a = pick_fwd(match1, exe_is_load);
    fwd_sel_b = pick_fwd(match2, exe_is_load);
  end
`else
  logic unused_exe_is_load;
  assign unused_exe_is_load = exe_is_load;

  // WB is included because the regfile write lands too late for a same-cycle read.
  always_comb begin
    hazard    = (|match1) | (id_src2_used & (|match2));
    fwd_sel_a = FWD_RF;
    fwd_sel_b = FWD_RF;
  end
`endif

  always_comb begin
    freeze   = 1'b0;
    bubble   = 1'b0;
    flush_if = 1'b0;
    // A taken branch discards the ID instruction, so it overrides any stall.
    if (exe_br_taken) begin
      flush_if = 1'b1;
      bubble   = 1'b1;
    end else if (id_valid && hazard) begin
      freeze = 1'b1;
      bubble = 1'b1;
    end

    sb_in_valid = id_valid & id_wb_en & ~bubble;

    stall_cnt_d = stall_cnt_q;
    if (freeze && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
